// File: rtl/softmax_pkg.sv
// softmax_pkg: shared widths, FSM encodings and float constants for the softmax datapath
package softmax_pkg;

    localparam int DATALENGTH = 32;
    localparam int INPUTMAX = 5;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        INPUTSTREAM = 2'b01,
        OP          = 2'b10,
        OUTPUT      = 2'b11
    } state_t;

    localparam logic [31:0] ONE = 32'h3f800000;
    localparam logic [31:0] SIX = 32'h40c00000;

endpackage

// File: rtl/exp_sequencer_if.sv
// exp_sequencer_if: input stream, exponential-unit and output stream handshakes of the sequencer
interface exp_sequencer_if #(
    parameter int DATALENGTH = softmax_pkg::DATALENGTH
);

    logic [DATALENGTH-1:0] InData;
    logic                  InValid;
    logic                  InLast;
    logic                  InReady;
    logic [DATALENGTH-1:0] ExpA;
    logic                  ExpAStb;
    logic                  ExpAAck;
    logic [DATALENGTH-1:0] ExpZ;
    logic                  ExpZStb;
    logic                  ExpZAck;
    logic [DATALENGTH-1:0] OutData;
    logic                  OutValid;
    logic                  OutLast;
    logic                  OutReady;
    logic                  Busy;

    modport master (
        input  InData, InValid, InLast, ExpAAck, ExpZ, ExpZStb, OutReady,
        output InReady, ExpA, ExpAStb, ExpZAck, OutData, OutValid, OutLast, Busy
    );

    modport slave (
        output InData, InValid, InLast, ExpAAck, ExpZ, ExpZStb, OutReady,
        input  InReady, ExpA, ExpAStb, ExpZAck, OutData, OutValid, OutLast, Busy
    );

endinterface

// File: rtl/exp_sequencer.sv
// exp_sequencer: buffers one softmax vector, runs each element through a shared exp unit, streams results in order
module exp_sequencer
    import softmax_pkg::*;
#(
    parameter int DATALENGTH = softmax_pkg::DATALENGTH,
    parameter int INPUTMAX = softmax_pkg::INPUTMAX
) (
    input logic            Clock,
    input logic            Reset,
    exp_sequencer_if.master bus
);

    localparam int CW = $clog2(INPUTMAX + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(INPUTMAX - 1);

    state_t                state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         idx;
    logic [CW-1:0]         rd;
    logic [DATALENGTH-1:0] buffer [INPUTMAX];

    assign bus.InReady = state == IDLE || state == INPUTSTREAM;
    assign bus.Busy = state != IDLE;

    // One registered FSM: fill the buffer, exponentiate it in place one element at a time, then drain it
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            count <= '0;
            idx <= '0;
            rd <= '0;
            bus.ExpA <= '0;
            bus.ExpAStb <= 1'b0;
            bus.ExpZAck <= 1'b0;
            bus.OutData <= '0;
            bus.OutValid <= 1'b0;
            bus.OutLast <= 1'b0;
            for (int i = 0; i < INPUTMAX; i++) buffer[i] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.InValid) begin
                    buffer[0] <= bus.InData;
                    count <= CW'(1);
                    state <= (bus.InLast || INPUTMAX == 1) ? OP : INPUTSTREAM;
                end
                INPUTSTREAM: if (bus.InValid) begin
                    buffer[count] <= bus.InData;
                    count <= count + 1'b1;
                    if (bus.InLast || count == LAST_SLOT) state <= OP;
                end
                OP: begin
                    // Both flags low only on the first OP cycle; later requests chain directly off each capture
                    if (!bus.ExpAStb && !bus.ExpZAck) begin
                        bus.ExpAStb <= 1'b1;
                        bus.ExpA <= buffer[idx];
                    end else if (bus.ExpAStb && bus.ExpAAck) begin
                        bus.ExpAStb <= 1'b0;
                        bus.ExpZAck <= 1'b1;
                    end else if (bus.ExpZAck && bus.ExpZStb) begin
                        buffer[idx] <= bus.ExpZ;
                        bus.ExpZAck <= 1'b0;
                        idx <= idx + 1'b1;
                        if (idx == count - 1'b1) begin
                            state <= OUTPUT;
                            rd <= '0;
                            bus.OutValid <= 1'b1;
                            bus.OutData <= (idx == '0) ? bus.ExpZ : buffer[0];
                            bus.OutLast <= count == CW'(1);
                        end else begin
                            bus.ExpAStb <= 1'b1;
                            bus.ExpA <= buffer[idx + 1'b1];
                        end
                    end
                end
                OUTPUT: if (bus.OutReady) begin
                    if (bus.OutLast) begin
                        state <= IDLE;
                        count <= '0;
                        idx <= '0;
                        rd <= '0;
                        bus.OutValid <= 1'b0;
                        bus.OutLast <= 1'b0;
                    end else begin
                        rd <= rd + 1'b1;
                        bus.OutData <= buffer[rd + 1'b1];
                        bus.OutLast <= rd + 1'b1 == count - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_sequencer.sv
// tb_exp_sequencer: table-driven and randomized batches against a list-level softmax-exp reference
module tb_exp_sequencer;
    import softmax_pkg::*;

    typedef struct packed {
        logic [5:0][31:0] din;
        int               n;
        int               last_at;
        int               delay;
        logic             tog;
        int               n_out;
        logic [4:0][31:0] dout;
    } vec_t;

    localparam logic [31:0] D0 = 32'h00000000;
    localparam logic [31:0] D2 = 32'h40000000;
    localparam logic [31:0] E0 = 32'h3f800000;
    localparam logic [31:0] E1 = 32'h402df854;
    localparam logic [31:0] E2 = 32'h40ec7326;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_delay = 0;
    bit tog = 1'b0;
    bit expect_abort = 1'b0;
    int z_timeouts = 0;
    int viol = 0;
    int a_cnt = 0;
    int pend = 0;
    int first_ov = -1;
    int accepted = 0;
    logic [31:0] out_d [$];
    logic        out_l [$];
    int          z_cyc [$];
    logic [31:0] want_q [$];
    logic [31:0] in_d [8];
    logic        in_l [8];
    vec_t        tbl [4];

    exp_sequencer_if #(.DATALENGTH(DATALENGTH)) b ();

    exp_sequencer #(.DATALENGTH(DATALENGTH), .INPUTMAX(INPUTMAX)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(b)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [31:0] exp_of(input logic [31:0] x);
        case (x)
            ONE:     return E1;
            D0:      return E0;
            D2:      return E2;
            default: return x ^ 32'h5a5a5a5a;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(3, 0))
            0:       return ONE;
            1:       return D0;
            2:       return D2;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // exponential unit: ack after exp_delay cycles, answer exp_delay cycles after the ack, hold ZStb until taken
    initial begin : exp_model
        logic [31:0] a;
        int w;
        b.ExpAAck = 1'b0;
        b.ExpZStb = 1'b0;
        b.ExpZ = '0;
        step();
        forever begin
            if (Reset && b.ExpAStb) begin
                repeat (exp_delay) step();
                b.ExpAAck = 1'b1;
                a = b.ExpA;
                step();
                b.ExpAAck = 1'b0;
                repeat (exp_delay) step();
                b.ExpZ = exp_of(a);
                b.ExpZStb = 1'b1;
                w = 0;
                while (!b.ExpZAck && w < 16) begin
                    step();
                    w++;
                end
                if (!b.ExpZAck) begin
                    if (!expect_abort) z_timeouts++;
                    b.ExpZStb = 1'b0;
                end else begin
                    step();
                    b.ExpZStb = 1'b0;
                end
            end else begin
                step();
            end
        end
    end

    initial begin : out_ready_drv
        b.OutReady = 1'b1;
        forever begin
            step();
            b.OutReady = tog ? ~b.OutReady : 1'b1;
        end
    end

    // protocol monitor sampled mid-cycle: holds, single outstanding request, output capture, timing marks
    initial begin : monitor
        bit hold_a, hold_o;
        logic [31:0] last_a, last_od;
        logic last_ol;
        hold_a = 0;
        hold_o = 0;
        last_a = '0;
        last_od = '0;
        last_ol = 0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                pend = 0;
                hold_a = 0;
                hold_o = 0;
            end else begin
                if (hold_a && (!b.ExpAStb || b.ExpA !== last_a)) viol++;
                if (hold_o && (!b.OutValid || b.OutData !== last_od || b.OutLast !== last_ol)) viol++;
                hold_a = b.ExpAStb && !b.ExpAAck;
                last_a = b.ExpA;
                hold_o = b.OutValid && !b.OutReady;
                last_od = b.OutData;
                last_ol = b.OutLast;
                if (b.ExpAStb && b.ExpZAck) viol++;
                if (b.ExpAStb && b.ExpAAck) begin
                    a_cnt++;
                    pend++;
                end
                if (b.ExpZAck && b.ExpZStb) begin
                    pend--;
                    z_cyc.push_back(cyc);
                end
                if (pend > 1 || pend < 0) viol++;
                if (b.OutValid && first_ov < 0) first_ov = cyc;
                if (b.OutValid && b.OutReady) begin
                    out_d.push_back(b.OutData);
                    out_l.push_back(b.OutLast);
                end
            end
        end
    end

    task automatic drive(input int n);
        int w;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            b.InValid = 1'b1;
            b.InData = in_d[i];
            b.InLast = in_l[i];
            while (!b.InReady && w < 3) begin
                step();
                w++;
            end
            if (!b.InReady) break;
            step();
            accepted++;
        end
        b.InValid = 1'b0;
        b.InLast = 1'b0;
        b.InData = '0;
    endtask

    task automatic run(input int n, input int delay, input bit tg, input string tag);
        int w, a_base, v_base;
        out_d.delete();
        out_l.delete();
        z_cyc.delete();
        first_ov = -1;
        a_base = a_cnt;
        v_base = viol;
        exp_delay = delay;
        tog = tg;
        drive(n);
        check($sformatf("%s accepted", tag), 32'(accepted), 32'(want_q.size()));
        check($sformatf("%s inready after last beat", tag), 32'(b.InReady), 32'd0);
        w = 0;
        while ((out_d.size() < want_q.size() || b.Busy) && w < 300) begin
            step();
            w++;
        end
        tog = 1'b0;
        check($sformatf("%s drained in time", tag), 32'(w < 300), 32'd1);
        check($sformatf("%s output count", tag), 32'(out_d.size()), 32'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < out_d.size(); i++) begin
            check($sformatf("%s out%0d data", tag, i), out_d[i], want_q[i]);
            check($sformatf("%s out%0d last", tag, i), 32'(out_l[i]), 32'(i == want_q.size() - 1));
        end
        check($sformatf("%s expA transfers", tag), 32'(a_cnt - a_base), 32'(want_q.size()));
        check($sformatf("%s protocol violations", tag), 32'(viol), 32'(v_base));
        check($sformatf("%s back to idle", tag), {b.Busy, b.InReady}, 32'b01);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w, k, n, last_at;
        b.InValid = 1'b0;
        b.InLast = 1'b0;
        b.InData = '0;

        tbl[0] = '{din: {D0, D0, D0, D2, D0, ONE}, n: 3, last_at: 3, delay: 0, tog: 1'b0, n_out: 3, dout: {D0, D0, E2, E0, E1}};
        tbl[1] = '{din: {D2, D0, ONE, D2, D0, ONE}, n: 6, last_at: 0, delay: 1, tog: 1'b0, n_out: 5, dout: {E0, E1, E2, E0, E1}};
        tbl[2] = '{din: {D0, D0, D0, D0, D0, D2}, n: 1, last_at: 1, delay: 2, tog: 1'b0, n_out: 1, dout: {D0, D0, D0, D0, E2}};
        tbl[3] = '{din: {D0, D0, D0, D2, D0, ONE}, n: 3, last_at: 3, delay: 4, tog: 1'b1, n_out: 3, dout: {D0, D0, E2, E0, E1}};

        #12;
        check("reset strobes", {b.ExpAStb, b.ExpZAck, b.OutValid, b.OutLast, b.Busy}, 32'd0);
        check("reset expA", b.ExpA, 32'd0);
        check("reset outdata", b.OutData, 32'd0);
        step();
        Reset = 1'b1;
        step();
        check("after reset inready", 32'(b.InReady), 32'd1);
        check("after reset busy", 32'(b.Busy), 32'd0);

        for (int t = 0; t < 4; t++) begin
            want_q.delete();
            for (int i = 0; i < 6; i++) begin
                in_d[i] = tbl[t].din[i];
                in_l[i] = (i + 1 == tbl[t].last_at);
            end
            for (int i = 0; i < tbl[t].n_out; i++) want_q.push_back(tbl[t].dout[i]);
            run(tbl[t].n, tbl[t].delay, tbl[t].tog, $sformatf("s%0d", t + 1));
            if (t == 0) begin
                check("s1 z transfer count", 32'(z_cyc.size()), 32'd3);
                if (z_cyc.size() == 3) begin
                    check("s1 cycles per element a", 32'(z_cyc[1] - z_cyc[0]), 32'd2);
                    check("s1 cycles per element b", 32'(z_cyc[2] - z_cyc[1]), 32'd2);
                    check("s1 first outvalid latency", 32'(first_ov - z_cyc[2]), 32'd1);
                end
            end
        end

        expect_abort = 1'b1;
        exp_delay = 4;
        in_d[0] = ONE;
        in_l[0] = 1'b1;
        drive(1);
        w = 0;
        while (!b.ExpZAck && w < 30) begin
            step();
            w++;
        end
        check("s5 request pending", 32'(b.ExpZAck), 32'd1);
        Reset = 1'b0;
        step();
        check("s5 in reset", {b.ExpAStb, b.ExpZAck, b.Busy, b.OutValid}, 32'd0);
        Reset = 1'b1;
        w = 0;
        while (!b.ExpZStb && w < 20) begin
            step();
            w++;
        end
        check("s5 late zstb seen", 32'(b.ExpZStb), 32'd1);
        check("s5 late zstb ignored", {b.ExpZAck, b.Busy, b.InReady}, 32'b001);
        step();
        check("s5 still ignored", {b.ExpZAck, b.Busy, b.InReady}, 32'b001);
        w = 0;
        while (b.ExpZStb && w < 40) begin
            step();
            w++;
        end
        expect_abort = 1'b0;
        in_d[0] = D0;
        in_l[0] = 1'b1;
        want_q.delete();
        want_q.push_back(E0);
        run(1, 0, 1'b0, "s5 batch");

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(7, 1);
            last_at = $urandom_range(8, 1);
            if (last_at > n && n < INPUTMAX) last_at = n;
            for (int i = 0; i < 8; i++) begin
                in_d[i] = pick();
                in_l[i] = (i + 1 == last_at);
            end
            k = (last_at < n) ? last_at : n;
            if (k > INPUTMAX) k = INPUTMAX;
            want_q.delete();
            for (int i = 0; i < k; i++) want_q.push_back(exp_of(in_d[i]));
            run(n, $urandom_range(4, 0), 1'($urandom_range(1, 0)), $sformatf("rand%0d", r));
        end

        check("exp model timeouts", 32'(z_timeouts), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
